system_0_sysid_checker: RTL and testbench

- Avalon-MM master that sits directly upstream of the system ID slave (control_slave) and consumes its readdata.
- After reset or on request, reads word 0 (system ID) and word 1 (build timestamp), then compares each against expected values.
- Reports match, mismatch or timeout status to boot/status logic, so a mismatched bitstream/software pairing is flagged in hardware.

---
 rtl/system_0_sysid_checker.sv | 195 +++++++++++++++++++
 tb/tb_system_0_sysid_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_0_sysid_checker.sv
// system_0_sysid_checker: Avalon-MM master that reads the sysid ID and timestamp words and flags mismatches.
// Optional feature macro SYSID_CHECK_RETRY_EN: retry a failing check up to MAX_RETRY extra times.
module system_0_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1328261165,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned AUTO_START     = 1,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic [31:0] av_readdata,
    input  logic        av_waitrequest,
    input  logic        av_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    // The timeout counter is 8 bits and the retry counter 2 bits.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || MAX_RETRY > 3) begin : g_bad_param
        $error("system_0_sysid_checker: TIMEOUT_CYCLES must be 1..255 and MAX_RETRY 0..3");
    end

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        WT_ID,
        RD_TS,
        WT_TS,
        DONE
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             auto_pend, auto_d;
    logic             av_read_d, av_address_d;
    logic             busy_d, done_d, id_ok_d, ts_ok_d, timeout_err_d;
    logic [31:0]      id_value_d, ts_value_d;
    logic             launch, finish;
`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0]       retry_cnt, retry_d;
`endif

    // Next-state and next-output logic; every output is registered from its _d value.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        auto_d        = 1'b0;
        av_read_d     = 1'b0;
        av_address_d  = av_address;
        busy_d        = busy;
        done_d        = done;
        id_ok_d       = id_ok;
        ts_ok_d       = ts_ok;
        timeout_err_d = timeout_err;
        id_value_d    = id_value;
        ts_value_d    = ts_value;
        launch        = 1'b0;
        finish        = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
        retry_d       = retry_cnt;
`endif

        case (state)
            IDLE, DONE: begin
                if (start || auto_pend) begin
                    launch = 1'b1;
`ifdef SYSID_CHECK_RETRY_EN
                    retry_d = 2'd0;
`endif
                end
            end
            RD_ID, RD_TS: begin
                if (cnt == TMO) begin
                    timeout_err_d = 1'b1;
                    finish        = 1'b1;
                end else if (av_read && !av_waitrequest) begin
                    state_d = (state == RD_ID) ? WT_ID : WT_TS;
                    cnt_d   = cnt + CNT_W'(1);
                end else begin
                    // Slave stalling: hold the request unchanged.
                    av_read_d = 1'b1;
                    cnt_d     = cnt + CNT_W'(1);
                end
            end
            WT_ID: begin
                // Data arriving on the timeout cycle still counts.
                if (av_readdatavalid) begin
                    id_value_d   = av_readdata;
                    id_ok_d      = (av_readdata == EXPECTED_ID);
                    state_d      = RD_TS;
                    cnt_d        = '0;
                    av_read_d    = 1'b1;
                    av_address_d = 1'b1;
                end else if (cnt == TMO) begin
                    timeout_err_d = 1'b1;
                    finish        = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            WT_TS: begin
                if (av_readdatavalid) begin
                    ts_value_d = av_readdata;
                    ts_ok_d    = (av_readdata == EXPECTED_TS);
                    finish     = 1'b1;
                end else if (cnt == TMO) begin
                    timeout_err_d = 1'b1;
                    finish        = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef SYSID_CHECK_RETRY_EN
            // A failed attempt relaunches while budget remains; the last one reports.
            if ((timeout_err_d || !id_ok_d || !ts_ok_d) && (retry_cnt < 2'(MAX_RETRY))) begin
                retry_d = retry_cnt + 2'd1;
                launch  = 1'b1;
            end
`endif
        end

        if (launch) begin
            state_d       = RD_ID;
            cnt_d         = '0;
            av_read_d     = 1'b1;
            av_address_d  = 1'b0;
            busy_d        = 1'b1;
            done_d        = 1'b0;
            id_ok_d       = 1'b0;
            ts_ok_d       = 1'b0;
            timeout_err_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            auto_pend   <= (AUTO_START != 0);
            av_read     <= 1'b0;
            av_address  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            auto_pend   <= auto_d;
            av_read     <= av_read_d;
            av_address  <= av_address_d;
            busy        <= busy_d;
            done        <= done_d;
            id_ok       <= id_ok_d;
            ts_ok       <= ts_ok_d;
            timeout_err <= timeout_err_d;
            id_value    <= id_value_d;
            ts_value    <= ts_value_d;
        end
    end

`ifdef SYSID_CHECK_RETRY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retry_cnt <= 2'd0;
        end else begin
            retry_cnt <= retry_d;
        end
    end
`endif

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// tb_system_0_sysid_checker: scoreboard bench for the sysid checker with a behavioural Avalon slave.
module tb_system_0_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1328261165;
    localparam int          TMO    = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        av_address, av_read, busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;
    logic [31:0] av_readdata = '0;
    logic        av_waitrequest = 1'b0;
    logic        av_readdatavalid = 1'b0;

    int total = 0;
    int bad   = 0;

    system_0_sysid_checker #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(TMO),
        .AUTO_START    (1),
        .MAX_RETRY     (3)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .av_address      (av_address),
        .av_read         (av_read),
        .av_readdata     (av_readdata),
        .av_waitrequest  (av_waitrequest),
        .av_readdatavalid(av_readdatavalid),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    // Slave model knobs and bookkeeping
    int          stall_id = 0;
    int          id_delay = 1;
    int          ts_delay = 1;
    bit          mute = 1'b0;
    bit          stray = 1'b0;
    logic [31:0] id_data = EXP_ID;
    logic [31:0] ts_data = EXP_TS;
    int          acc_cnt = 0;
    int          stall_seen = 0;
    int          stall_bad = 0;
    bit          in_req = 1'b0;
    logic        req_addr = 1'b0;
    int          stall_left = 0;
    bit          pend = 1'b0;
    int          pend_t = 0;
    logic [31:0] pend_data = '0;

    // Slave drives on the falling edge; the DUT samples on the rising edge.
    always @(negedge clock) begin
        av_readdatavalid = 1'b0;
        if (stray) begin
            av_readdatavalid = 1'b1;
            av_readdata      = 32'hDEAD_BEEF;
            stray            = 1'b0;
        end
        if (reset) begin
            pend           = 1'b0;
            in_req         = 1'b0;
            av_waitrequest = 1'b0;
        end else begin
            if (pend) begin
                pend_t = pend_t - 1;
                if (pend_t == 0) begin
                    av_readdatavalid = 1'b1;
                    av_readdata      = pend_data;
                    pend             = 1'b0;
                end
            end
            if (av_read) begin
                if (!in_req) begin
                    in_req     = 1'b1;
                    req_addr   = av_address;
                    stall_left = (av_address == 1'b0) ? stall_id : 0;
                end
                if (av_address !== req_addr) stall_bad++;
                if (stall_left > 0) begin
                    av_waitrequest = 1'b1;
                    stall_left     = stall_left - 1;
                    stall_seen++;
                end else begin
                    av_waitrequest = 1'b0;
                    in_req         = 1'b0;
                    acc_cnt++;
                    if (!mute) begin
                        pend      = 1'b1;
                        pend_t    = av_address ? ts_delay : id_delay;
                        pend_data = av_address ? ts_data : id_data;
                    end
                end
            end else begin
                if (in_req) stall_bad++;
                av_waitrequest = 1'b0;
                in_req         = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    typedef struct {
        logic        idok;
        logic        tsok;
        logic        tmo;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          lat;
        int          reads;
    } exp_t;

    exp_t exp_q[$];
    int   base_reads = 0;

    task automatic expect_run(input logic idok, input logic tsok, input logic tmo,
                              input logic [31:0] idv, input logic [31:0] tsv,
                              input int lat, input int reads);
        exp_t e;
        e.idok  = idok;
        e.tsok  = tsok;
        e.tmo   = tmo;
        e.idv   = idv;
        e.tsv   = tsv;
        e.lat   = lat;
        e.reads = reads;
        exp_q.push_back(e);
        base_reads = acc_cnt;
    endtask

    // Count cycles until done, optionally poking start mid-run, then score against the queue head.
    task automatic wait_done(input int poke, input bit probe);
        int   lat;
        exp_t e;
        lat = 0;
        while (lat < 400) begin
            tick();
            lat++;
            start = (lat == poke);
            if (probe && lat == 1) begin
                check("restart_done", done, 1'b0);
                check("restart_tmo", timeout_err, 1'b0);
                check("restart_busy", busy, 1'b1);
                check("restart_read", av_read, 1'b1);
                check("restart_addr", av_address, 1'b0);
            end
            if (done) break;
        end
        if (lat >= 400) check("done_wait", 32'd0, 32'd1);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("latency", lat, e.lat);
            check("id_ok", id_ok, e.idok);
            check("ts_ok", ts_ok, e.tsok);
            check("timeout_err", timeout_err, e.tmo);
            check("id_value", id_value, e.idv);
            check("ts_value", ts_value, e.tsv);
            check("reads", acc_cnt - base_reads, e.reads);
            check("busy_end", busy, 1'b0);
            check("read_end", av_read, 1'b0);
        end
    endtask

    initial begin
        repeat (2) tick();
        check("rst_read", av_read, 1'b0);
        check("rst_addr", av_address, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_id_ok", id_ok, 1'b0);
        check("rst_ts_ok", ts_ok, 1'b0);
        check("rst_tmo", timeout_err, 1'b0);
        check("rst_idv", id_value, 32'd0);
        check("rst_tsv", ts_value, 32'd0);

        // Auto-start after reset release, minimum latency
        expect_run(1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 5, 2);
        reset = 1'b0;
        wait_done(0, 1'b0);

        // ID read stalled four cycles
        stall_id   = 4;
        stall_seen = 0;
        stall_bad  = 0;
        expect_run(1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 9, 2);
        start = 1'b1;
        wait_done(0, 1'b0);
        check("stall_cycles", stall_seen, 4);
        check("stall_stable", stall_bad, 0);
        stall_id = 0;

        // Timestamp off by one
        ts_data = EXP_TS + 32'd1;
`ifdef SYSID_CHECK_RETRY_EN
        expect_run(1'b1, 1'b0, 1'b0, EXP_ID, EXP_TS + 32'd1, 17, 8);
`else
        expect_run(1'b1, 1'b0, 1'b0, EXP_ID, EXP_TS + 32'd1, 5, 2);
`endif
        start = 1'b1;
        wait_done(0, 1'b0);

        // Slave never returns data: timeout on the ID read
        mute = 1'b1;
`ifdef SYSID_CHECK_RETRY_EN
        expect_run(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS + 32'd1, 69, 4);
`else
        expect_run(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS + 32'd1, 18, 1);
`endif
        start = 1'b1;
        wait_done(0, 1'b0);
        mute    = 1'b0;
        ts_data = EXP_TS;

        // Restart from DONE clears the flags and reissues the ID read
        expect_run(1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 5, 2);
        start = 1'b1;
        wait_done(0, 1'b1);

        // Data on exactly the timeout cycle wins; a start pulse mid-run is ignored
        id_delay = TMO;
        expect_run(1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 20, 2);
        start = 1'b1;
        wait_done(8, 1'b0);

        // Data one cycle too late times out
        id_delay = TMO + 1;
`ifdef SYSID_CHECK_RETRY_EN
        expect_run(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS, 69, 4);
`else
        expect_run(1'b0, 1'b0, 1'b1, EXP_ID, EXP_TS, 18, 1);
`endif
        start = 1'b1;
        wait_done(0, 1'b0);
        id_delay = 1;
        repeat (20) tick();

        // Reset while waiting for the timestamp, then a stray readdatavalid in IDLE
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_addr", av_address, 1'b1);
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_addr", av_address, 1'b0);
        check("arst_id_ok", id_ok, 1'b0);
        check("arst_tsv", ts_value, 32'd0);
        check("arst_done", done, 1'b0);
        stray = 1'b1;
        tick();
        expect_run(1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS, 5, 2);
        reset = 1'b0;
        wait_done(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=stuck want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
